// File: rtl/ans_ht_stf_sequencer_if.sv
// rtl/ans_ht_stf_sequencer_if.sv - valid/ready sample stream between the HT-STF sequencer and the tx sample mux
interface ans_ht_stf_sequencer_if;
   logic [31:0] tdata;
   logic        tvalid;
   logic        tready;
   logic        tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/ans_ht_stf_sequencer.sv
// rtl/ans_ht_stf_sequencer.sv - HT-STF generator sequencer, burst capture buffer and gained output stream
// Define ANS_STF_WINDOW_EN to halve samples 0 and STF_LEN-1 (adds one output pipeline stage).
module ans_ht_stf_sequencer #(
   parameter int STF_LEN       = 80,
   parameter int FFT_LEN       = 64,
   parameter int GEN_LATENCY   = 160,
   parameter int START_TIMEOUT = 32,
   parameter int AW            = 7,
   parameter int GAIN_SHIFT    = 0
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   tx_start,
   input  logic [127:0]           obf_coeff_in,
   output logic [127:0]           gen_obf_coeff,
   output logic                   gen_letsgo,
   output logic                   gen_givemeoutput,
   input  logic [31:0]            stf_sample_in,
   input  logic                   stf_started_in,
   ans_ht_stf_sequencer_if.master m,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   localparam int CW = $clog2((GEN_LATENCY > START_TIMEOUT ? GEN_LATENCY : START_TIMEOUT) + 1);
   localparam int IW = $clog2(STF_LEN + 1);
`ifdef ANS_STF_WINDOW_EN
   localparam int MW = 34;
`else
   localparam int MW = 33;
`endif

   generate
      if (STF_LEN > (1 << AW)) begin : g_bad_depth
         $error("ans_ht_stf_sequencer: buffer depth 2**AW is smaller than STF_LEN");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE, S_KICK, S_WAIT_GEN, S_REQ, S_CAPTURE, S_DRAIN, S_DONE
   } state_t;

   state_t         r_state;
   logic [127:0]   r_obf;
   logic           r_letsgo;
   logic           r_req;
   logic           r_busy;
   logic           r_done;
   logic           r_err;
   logic           r_started_d;
   logic [CW-1:0]  r_cnt;
   logic [IW-1:0]  r_idx;

   logic [MW-1:0]  r_mem [0:(1<<AW)-1];
   logic [AW-1:0]  r_wptr;
   logic [AW-1:0]  r_rptr;
   logic [AW:0]    r_count;

   logic [31:0]    r_tdata;
   logic           r_tvalid;
   logic           r_tlast;

   logic           w_rise;
   logic           w_wr;
   logic           w_last;
   logic           w_pop;
   logic           w_out_ld;
   logic           w_drained;
   logic [MW-1:0]  w_wr_word;
   logic [MW-1:0]  w_rd;
   logic [31:0]    w_gain_in;
   logic           w_gain_last;

   function automatic logic [15:0] f_gain(input logic [15:0] x);
      logic signed [18:0] v;
      v = $signed({{3{x[15]}}, x}) <<< GAIN_SHIFT;
      if (v > 19'sd32767)
         return 16'h7FFF;
      else if (v < -19'sd32768)
         return 16'h8000;
      else
         return v[15:0];
   endfunction

   assign w_rise = stf_started_in & ~r_started_d;
   assign w_last = (r_state == S_CAPTURE) && (r_idx == IW'(STF_LEN - 1));
   // Sample 0 is written in the REQ cycle where started rises, the rest during CAPTURE.
   assign w_wr   = ((r_state == S_REQ) && w_rise) || (r_state == S_CAPTURE);
   assign w_rd   = r_mem[r_rptr];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= S_IDLE;
         r_obf       <= '0;
         r_letsgo    <= 1'b0;
         r_req       <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_started_d <= 1'b0;
         r_cnt       <= '0;
         r_idx       <= '0;
      end else begin
         r_letsgo    <= 1'b0;
         r_done      <= 1'b0;
         r_started_d <= stf_started_in;
         case (r_state)
            S_IDLE: begin
               if (tx_start) begin
                  r_obf    <= obf_coeff_in;
                  r_err    <= 1'b0;
                  r_busy   <= 1'b1;
                  r_letsgo <= 1'b1;
                  r_state  <= S_KICK;
               end
            end
            S_KICK: begin
               r_cnt   <= '0;
               r_state <= S_WAIT_GEN;
            end
            S_WAIT_GEN: begin
               if (r_cnt == CW'(GEN_LATENCY - 1)) begin
                  r_cnt   <= '0;
                  r_req   <= 1'b1;
                  r_state <= S_REQ;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_REQ: begin
               if (w_rise) begin
                  r_req   <= 1'b0;
                  r_idx   <= IW'(1);
                  r_state <= S_CAPTURE;
               end else if (r_cnt == CW'(START_TIMEOUT - 1)) begin
                  r_req   <= 1'b0;
                  r_err   <= 1'b1;
                  r_state <= S_DRAIN;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_CAPTURE: begin
               // The generator's started flag must cover exactly the IFFT part of the burst.
               if (stf_started_in != (r_idx < IW'(FFT_LEN)))
                  r_err <= 1'b1;
               if (w_last)
                  r_state <= S_DRAIN;
               else
                  r_idx <= r_idx + 1'b1;
            end
            S_DRAIN: begin
               if (w_drained) begin
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr)
         r_mem[r_wptr] <= w_wr_word;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_wr)
            r_wptr <= r_wptr + 1'b1;
         if (w_pop)
            r_rptr <= r_rptr + 1'b1;
         r_count <= r_count + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_pop};
      end
   end

`ifdef ANS_STF_WINDOW_EN
   logic        r_s1_valid;
   logic        r_s1_last;
   logic [31:0] r_s1_data;

   assign w_wr_word   = {(r_state == S_REQ), w_last, stf_sample_in};
   assign w_out_ld    = r_s1_valid && (!r_tvalid || m.tready);
   assign w_pop       = (r_count != '0) && (!r_s1_valid || w_out_ld);
   assign w_drained   = (r_count == '0) && !r_s1_valid && (!r_tvalid || m.tready);
   assign w_gain_in   = r_s1_data;
   assign w_gain_last = r_s1_last;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_s1_valid <= 1'b0;
         r_s1_last  <= 1'b0;
         r_s1_data  <= '0;
      end else if (w_pop) begin
         r_s1_valid <= 1'b1;
         r_s1_last  <= w_rd[32];
         r_s1_data  <= (w_rd[33] || w_rd[32]) ?
                       {w_rd[31], w_rd[31:17], w_rd[15], w_rd[15:1]} : w_rd[31:0];
      end else if (w_out_ld) begin
         r_s1_valid <= 1'b0;
      end
   end
`else
   assign w_wr_word   = {w_last, stf_sample_in};
   assign w_out_ld    = (r_count != '0) && (!r_tvalid || m.tready);
   assign w_pop       = w_out_ld;
   assign w_drained   = (r_count == '0) && (!r_tvalid || m.tready);
   assign w_gain_in   = w_rd[31:0];
   assign w_gain_last = w_rd[32];
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_tvalid <= 1'b0;
         r_tdata  <= '0;
         r_tlast  <= 1'b0;
      end else if (w_out_ld) begin
         r_tvalid <= 1'b1;
         r_tdata  <= {f_gain(w_gain_in[31:16]), f_gain(w_gain_in[15:0])};
         r_tlast  <= w_gain_last;
      end else if (m.tready) begin
         r_tvalid <= 1'b0;
      end
   end

   assign gen_obf_coeff    = r_obf;
   assign gen_letsgo       = r_letsgo;
   assign gen_givemeoutput = r_req;
   assign busy             = r_busy;
   assign done             = r_done;
   assign err              = r_err;
   assign m.tdata          = r_tdata;
   assign m.tvalid         = r_tvalid;
   assign m.tlast          = r_tlast;

endmodule
